// File: rtl/line_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_ctrl
// Description : Raster sequencer for the Sobel front end. Generates de/hsync/
//               vsync, tracks pixel column/row, and flags line_buffer window
//               outputs that are full 3x3 neighbourhoods, tagged with the
//               window centre coordinates.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           clock, rising edge
//   rst           synchronous reset, active-low (0 = reset)
//   i_start       frame request, sampled in IDLE only
//   i_stop        sticky request: finish current frame, then idle
//   o_de          active pixel strobe
//   o_hsync       one-cycle pulse after each line's last de cycle
//   o_vsync       high for the whole vertical blank
//   o_busy        high while a frame is in progress
//   o_frame_done  one-cycle pulse after the last vertical blank cycle
//   o_col/o_row   position of the current de pixel
//   o_win_valid   line_buffer window is a full 3x3 neighbourhood
//   o_win_x/y     window centre coordinates (held while o_win_valid = 0)
// Configuration
//   LBCTRL_CONTINUOUS_EN : when defined, frames run back-to-back after one
//                          start until the stop latch is set.
// ============================================================================
module line_buffer_ctrl #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 5,
  parameter int HBLANK = 4,
  parameter int VBLANK = 6,
  parameter int LB_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_stop,
  output logic                      o_de,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic [$clog2(WIDTH)-1:0]  o_col,
  output logic [$clog2(HEIGHT)-1:0] o_row,
  output logic                      o_win_valid,
  output logic [$clog2(WIDTH)-1:0]  o_win_x,
  output logic [$clog2(HEIGHT)-1:0] o_win_y
);

  localparam int CW   = $clog2(WIDTH);
  localparam int RW   = $clog2(HEIGHT);
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LINE = 2'd1,
    S_HBL  = 2'd2,
    S_VBL  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [BW-1:0]   r_bcnt;
  logic            r_stop;
  logic            r_de;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_busy;
  logic            r_frame_done;

  // ------------------------------------------------------------------------
  // Raster FSM; all outputs are registered alongside the state.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_bcnt       <= '0;
      r_stop       <= 1'b0;
      r_de         <= 1'b0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_hsync      <= 1'b0;
      r_frame_done <= 1'b0;
      if (r_busy && i_stop) begin
        r_stop <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_LINE;
            r_de    <= 1'b1;
            r_busy  <= 1'b1;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        S_LINE: begin
          if (r_col == CW'(WIDTH - 1)) begin
            // Every line, including the last, ends with one hsync pulse.
            r_de    <= 1'b0;
            r_hsync <= 1'b1;
            r_bcnt  <= '0;
            if (r_row == RW'(HEIGHT - 1)) begin
              r_state <= S_VBL;
              r_vsync <= 1'b1;
            end else begin
              r_state <= S_HBL;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_HBL: begin
          if (r_bcnt == BW'(HBLANK - 1)) begin
            r_state <= S_LINE;
            r_de    <= 1'b1;
            r_col   <= '0;
            r_row   <= r_row + 1'b1;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        S_VBL: begin
          if (r_bcnt == BW'(VBLANK - 1)) begin
            r_vsync      <= 1'b0;
            r_frame_done <= 1'b1;
`ifdef LBCTRL_CONTINUOUS_EN
            if (!r_stop) begin
              r_state <= S_LINE;
              r_de    <= 1'b1;
              r_col   <= '0;
              r_row   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_stop  <= 1'b0;
            end
`else
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_stop  <= 1'b0;
`endif
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Window tracking: a pixel completes a 3x3 neighbourhood once two full
  // rows and two full columns precede it; the centre is one up and one left.
  // ------------------------------------------------------------------------
  logic          w_tap;
  logic [CW-1:0] w_tap_x;
  logic [RW-1:0] w_tap_y;

  assign w_tap   = r_de && (r_col >= CW'(2)) && (r_row >= RW'(2));
  assign w_tap_x = r_col - 1'b1;
  assign w_tap_y = r_row - 1'b1;

  generate
    for (genvar g = 0; g < LB_LAT; g++) begin : g_pipe
      logic          w_vin;
      logic [CW-1:0] w_xin;
      logic [RW-1:0] w_yin;
      logic          r_v;
      logic [CW-1:0] r_x;
      logic [RW-1:0] r_y;

      if (g == 0) begin : g_first
        assign w_vin = w_tap;
        assign w_xin = w_tap_x;
        assign w_yin = w_tap_y;
      end else begin : g_rest
        assign w_vin = g_pipe[g-1].r_v;
        assign w_xin = g_pipe[g-1].r_x;
        assign w_yin = g_pipe[g-1].r_y;
      end

      // Coordinates only advance with a valid tap, so the final stage
      // naturally holds the last window centre between pulses.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_v <= 1'b0;
          r_x <= '0;
          r_y <= '0;
        end else begin
          r_v <= w_vin;
          if (w_vin) begin
            r_x <= w_xin;
            r_y <= w_yin;
          end
        end
      end
    end
  endgenerate

  assign o_de         = r_de;
  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_col        = r_col;
  assign o_row        = r_row;
  assign o_win_valid  = g_pipe[LB_LAT-1].r_v;
  assign o_win_x      = g_pipe[LB_LAT-1].r_x;
  assign o_win_y      = g_pipe[LB_LAT-1].r_y;

endmodule
`default_nettype wire
